// File: rtl/seg_scan_if.sv
// CPU-side config bus and display-side outputs of the seven-segment digit scanner.
`timescale 1ns/1ps
interface seg_scan_if;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  led_en;
    logic [2:0]  digit_idx;
    logic        slot_tick;
    logic [31:0] cfg_rdata;

    modport master (
        output addr, wen, wdata,
        input  led_en, digit_idx, slot_tick, cfg_rdata
    );

    modport slave (
        input  addr, wen, wdata,
        output led_en, digit_idx, slot_tick, cfg_rdata
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan driver: slot timing, dead-time blanking,
// per-digit mask and 16-level PWM brightness, config applied at slot boundaries.
`timescale 1ns/1ps
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave cpu
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ON_W  = $clog2(SCAN_DIV + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [ON_W+4:0]  SPAN    = (ON_W+5)'(SCAN_DIV - DEAD_CYC);
    localparam logic [ON_W:0]    DEAD_W  = (ON_W+1)'(DEAD_CYC);
    localparam logic [ON_W-1:0]  ON_RST  = ON_W'(SCAN_DIV - DEAD_CYC);

    // Product is kept ON_W+5 bits wide so span*16 never overflows before the shift.
    function automatic logic [ON_W-1:0] calc_on_len(input logic [3:0] bright);
        logic [ON_W+4:0] prod;
        prod = SPAN * (ON_W+5)'({1'b0, bright} + 5'd1);
        return prod[ON_W+3:4];
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_led_en;
    logic             r_tick;
    logic [7:0]       r_mask_pend;
    logic [3:0]       r_bright_pend;
    logic [7:0]       r_mask_act;
    logic [3:0]       r_bright_act;
    logic [ON_W-1:0]  r_on_len;

    logic             w_cfg_wr;
    logic             w_wrap;
    logic [7:0]       w_mask_nxt;
    logic [3:0]       w_bright_nxt;
    logic [ON_W:0]    w_cnt_ext;
    logic [ON_W:0]    w_on_end;
    logic             w_on;

    assign w_cfg_wr     = cpu.wen && (cpu.addr == 12'h004);
    assign w_wrap       = (r_cnt == CNT_MAX);
    assign w_mask_nxt   = w_cfg_wr ? cpu.wdata[7:0]  : r_mask_pend;
    assign w_bright_nxt = w_cfg_wr ? cpu.wdata[11:8] : r_bright_pend;

    // Window compared in ON_W+1 bits so DEAD_CYC+on_len (up to SCAN_DIV) cannot wrap.
    assign w_cnt_ext = (ON_W+1)'(r_cnt);
    assign w_on_end  = DEAD_W + {1'b0, r_on_len};
    assign w_on      = (w_cnt_ext >= DEAD_W) && (w_cnt_ext < w_on_end) && r_mask_act[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_led_en      <= 8'hFF;
            r_tick        <= 1'b0;
            r_mask_pend   <= 8'hFF;
            r_bright_pend <= 4'hF;
            r_mask_act    <= 8'hFF;
            r_bright_act  <= 4'hF;
            r_on_len      <= ON_RST;
        end else begin
            r_tick   <= w_wrap;
            r_led_en <= w_on ? ~(8'b1 << r_idx) : 8'hFF;
            if (w_cfg_wr) begin
                r_mask_pend   <= cpu.wdata[7:0];
                r_bright_pend <= cpu.wdata[11:8];
            end
            if (w_wrap) begin
                r_cnt        <= '0;
                r_idx        <= r_idx + 3'd1;
                r_mask_act   <= w_mask_nxt;
                r_bright_act <= w_bright_nxt;
                r_on_len     <= calc_on_len(w_bright_nxt);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cpu.led_en    = r_led_en;
    assign cpu.digit_idx = r_idx;
    assign cpu.slot_tick = r_tick;
    assign cpu.cfg_rdata = {20'b0, r_bright_act, r_mask_act};
endmodule
